// File: rtl/gray_arbiter_pkg.sv
// Shared types and helpers for the gray-code step-counter arbiter.
package gray_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_LEN_W = 4;
  localparam int GRAY_MAX  = 16;

  // Next gray code of width w (w <= GRAY_MAX); bits above w must be zero.
  function automatic logic [GRAY_MAX-1:0] gray_next(input logic [GRAY_MAX-1:0] g, input int w);
    logic [GRAY_MAX-1:0] b;
    logic [GRAY_MAX-1:0] m;
    b[GRAY_MAX-1] = g[GRAY_MAX-1];
    for (int i = GRAY_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    m = (GRAY_MAX'(1) << w) - GRAY_MAX'(1);
    b = (b + GRAY_MAX'(1)) & m;
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_arbiter_core.sv
// Gray-code step register: clear has priority over enable.
// Wrap pulses in the cycle the code returns to zero from the MSB-only code.
module gray_core
  import gray_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= WIDTH'(gray_next(GRAY_MAX'(q), WIDTH));
      wrap <= (q == MSB_ONLY);
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_arbiter.sv
// Round-robin owner of a shared gray step counter: grants one requester a burst
// of N steps, honours hold and abort, and pulses done on completion.
module gray_arbiter
  import gray_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             hold,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic [1:0]       done
);

  state_t           state, state_nx;
  logic [1:0]       grant_nx, done_nx;
  logic             busy_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic             last, last_nx;
  logic             win;
  logic             owner_req;
  logic             clr, en;

  gray_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .q     (gray),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      rem   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      done  <= done_nx;
      busy  <= busy_nx;
      rem   <= rem_nx;
      last  <= last_nx;
    end
  end

  // On a tie the requester not served last wins.
  assign win       = (req == 2'b11) ? ~last : req[1];
  assign owner_req = |(req & grant);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    done_nx  = 2'b00;
    busy_nx  = busy;
    rem_nx   = rem;
    last_nx  = last;
    clr      = 1'b0;
    en       = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          clr      = 1'b1;
          grant_nx = win ? 2'b10 : 2'b01;
          last_nx  = win;
          rem_nx   = win ? len1 : len0;
          busy_nx  = 1'b1;
          if (rem_nx == '0) begin
            state_nx = DONE;
            done_nx  = grant_nx;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
          busy_nx  = 1'b0;
        end else if (!hold) begin
          en     = 1'b1;
          rem_nx = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_nx = DONE;
            done_nx  = grant;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gray_arbiter.sv
// Scoreboard bench: a step-counting reference model predicts every cycle's outputs.
module tb_gray_arbiter;

  typedef struct packed {
    logic [1:0] grant;
    logic       busy;
    logic [2:0] gray;
    logic       wrap;
    logic [1:0] done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic       hold = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic [2:0] gray;
  logic       wrap;
  logic [1:0] done;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  obs_t exp_q[$];

  // Reference model: phase 0 idle, 1 run, 2 done; gray derived from step count.
  int m_phase = 0, m_owner = -1, m_left = 0, m_steps = 0, m_last = 1;
  logic m_wrap = 1'b0;
  logic [1:0] m_done = 2'b00;

  gray_arbiter #(.WIDTH(3), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1), .hold(hold),
    .grant(grant), .busy(busy), .gray(gray), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] to_gray(input int n);
    int k;
    k = n % 8;
    return 3'(k ^ (k >> 1));
  endfunction

  task automatic model_step(input logic [1:0] r, input int a, input int b, input logic h, input logic rs);
    obs_t o;
    m_wrap = 1'b0;
    m_done = 2'b00;
    if (!rs) begin
      m_phase = 0; m_owner = -1; m_left = 0; m_steps = 0; m_last = 1;
    end else if (m_phase == 0) begin
      if (r != 2'b00) begin
        m_owner = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
        m_last  = m_owner;
        m_left  = (m_owner == 1) ? b : a;
        m_steps = 0;
        if (m_left == 0) begin
          m_phase = 2;
          m_done  = 2'(1 << m_owner);
        end else begin
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (!r[m_owner]) begin
        m_phase = 0; m_owner = -1;
      end else if (!h) begin
        m_steps++;
        m_left--;
        if (m_steps % 8 == 0) m_wrap = 1'b1;
        if (m_left == 0) begin
          m_phase = 2;
          m_done  = 2'(1 << m_owner);
        end
      end
    end else begin
      m_phase = 0; m_owner = -1;
    end
    o.grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    o.busy  = (m_phase != 0);
    o.gray  = to_gray(m_steps);
    o.wrap  = m_wrap;
    o.done  = m_done;
    exp_q.push_back(o);
  endtask

  // Apply inputs for the next edge, predict its outputs, then step past the edge.
  task automatic cyc(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b, input logic h, input logic rs);
    req = r; len0 = a; len1 = b; hold = h; reset = rs;
    model_step(r, int'(a), int'(b), h, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{grant: grant, busy: busy, gray: gray, wrap: wrap, done: done};
      ncyc++;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got grant=%b busy=%b gray=%b wrap=%b done=%b want grant=%b busy=%b gray=%b wrap=%b done=%b",
                 ncyc, a.grant, a.busy, a.gray, a.wrap, a.done, e.grant, e.busy, e.gray, e.wrap, e.done);
      end
    end
  end

  initial begin
    #1;
    // Reset
    repeat (2) cyc(2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("reset_grant", int'(grant), 0);
    chk("reset_gray", int'(gray), 0);
    cyc(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);

    // Single burst of 3 for requester 0
    repeat (4) cyc(2'b01, 4'd3, 4'd0, 1'b0, 1'b1);
    chk("single_gray", int'(gray), 2);
    chk("single_done", int'(done), 1);
    repeat (2) cyc(2'b00, 4'd3, 4'd0, 1'b0, 1'b1);

    // Tie and fairness
    repeat (14) cyc(2'b11, 4'd2, 4'd2, 1'b0, 1'b1);
    repeat (2) cyc(2'b00, 4'd2, 4'd2, 1'b0, 1'b1);

    // Wrap inside a burst of 8
    repeat (9) cyc(2'b10, 4'd0, 4'd8, 1'b0, 1'b1);
    chk("wrap_pulse", int'(wrap), 1);
    chk("wrap_gray", int'(gray), 0);
    chk("wrap_done", int'(done), 2);
    repeat (2) cyc(2'b00, 4'd0, 4'd8, 1'b0, 1'b1);

    // Hold then abort
    repeat (3) cyc(2'b01, 4'd5, 4'd0, 1'b0, 1'b1);
    repeat (2) cyc(2'b01, 4'd5, 4'd0, 1'b1, 1'b1);
    chk("hold_gray", int'(gray), 3);
    cyc(2'b00, 4'd5, 4'd0, 1'b1, 1'b1);
    chk("abort_grant", int'(grant), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_gray", int'(gray), 3);
    cyc(2'b00, 4'd5, 4'd0, 1'b0, 1'b1);

    // Zero length
    cyc(2'b01, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("zero_grant", int'(grant), 1);
    chk("zero_done", int'(done), 1);
    chk("zero_wrap", int'(wrap), 0);
    repeat (2) cyc(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);

    // Reset mid-RUN, then a held request is granted right after release
    repeat (3) cyc(2'b01, 4'd7, 4'd0, 1'b0, 1'b1);
    cyc(2'b01, 4'd7, 4'd0, 1'b0, 1'b0);
    chk("midrst_busy", int'(busy), 0);
    cyc(2'b01, 4'd7, 4'd0, 1'b0, 1'b1);
    chk("release_grant", int'(grant), 1);
    repeat (8) cyc(2'b01, 4'd7, 4'd0, 1'b0, 1'b1);

    // Randomized segments
    for (int s = 0; s < 300; s++) begin
      logic [1:0] r;
      logic [3:0] a, b;
      int seg;
      r   = 2'($urandom_range(0, 3));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      seg = $urandom_range(1, 14);
      if ($urandom_range(0, 63) == 0) cyc(r, a, b, 1'b0, 1'b0);
      for (int c = 0; c < seg; c++) begin
        if ($urandom_range(0, 15) == 0) a = 4'($urandom_range(0, 15));
        cyc(r, a, b, ($urandom_range(0, 3) == 0), 1'b1);
      end
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_arbiter.md
# gray_arbiter

Shares one gray-code step counter between two requesters. Each requester asks for a burst of N gray steps. The block arbitrates round-robin, clears and steps the counter for the winner, and signals completion. It sits between client FSMs and the shared gray counter and owns the counter's enable and clear.

## Interface
- WIDTH, 3: gray code width.
- LEN_W, 4: width of the burst-length inputs.

- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Req  in  2  per-requester request level; held until Done or deliberately dropped to abort.
- Len0  in  LEN_W  burst length for requester 0; sampled only at grant.
- Len1  in  LEN_W  burst length for requester 1; sampled only at grant.
- Hold  in  1  pauses stepping while high.
- Grant  out  2  one-hot owner; 00 when idle.
- Busy  out  1  high in RUN or DONE.
- Gray  out  WIDTH  current gray code.
- Wrap  out  1  one-cycle pulse when Gray steps from the MSB-only code (100 for WIDTH=3) to 000.
- Done  out  2  one-cycle pulse on the completing requester's bit.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Req==00: stay in IDLE.
  - Otherwise pick a winner. If only one bit is set, that requester wins. If both are set, the requester not served last wins.
  - Register Grant, latch the winner's Len into Rem, and clear Gray to 0.
  - Go to RUN. If the latched Len==0, go straight to DONE instead.
- RUN:
  - Hold=1: Gray and Rem are frozen and no pulses are emitted.
  - Hold=0: Gray advances one gray step (000,001,011,010,110,111,101,100,000 for WIDTH=3) and Rem decrements.
  - If a step happens while Rem==1, go to DONE.
- RUN abort: if Req[owner]==0 on any RUN cycle, go to IDLE.
  - No step that cycle.
  - No Done pulse.
  - The last-served pointer is still updated.
- DONE:
  - Done[owner]=1 for exactly this cycle.
  - Grant is still asserted.
  - Unconditionally go to IDLE; re-arbitration happens there.
- Last-served pointer: updated at grant. Reset value is 1, so requester 0 wins the first tie.
- Gray keeps its final value after a burst until the next grant clears it.
- Req bits other than the owner's are ignored outside IDLE.
- Len changes after grant are ignored.
- Rem is LEN_W bits. The maximum burst is 2^LEN_W-1 steps; wrap-around of Gray within a burst is legal and repeats.

## Timing
- Reset (Reset=0 at an edge) applies in any state: state=IDLE, Grant=00, Busy=0, Gray=0, Wrap=0, Done=00, Rem=0, pointer=1.
- Request latency: Req seen in IDLE at edge t gives Grant and Busy high and Gray=0 at t+1.
- Step latency: a RUN cycle with Hold=0 updates Gray at the next edge. Wrap is registered together with that transition, so Wrap is high in the same cycle Gray first shows 000.
- A Len=L burst with no Hold is in RUN for L cycles, then DONE for one cycle, then IDLE for at least one cycle. That makes grant-to-grant spacing L+2 cycles minimum.
- A Len=0 grant is one grant cycle in DONE, then IDLE.
- Hold=1 together with a dropped Req: the abort wins.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH and LEN_W constants;
  - a gray-successor function (binary-convert, add 1, reconvert).
- One sub-module, gray_core: WIDTH-bit register with Clr (priority) and En inputs, and Q and Wrap outputs. It uses the same active-low synchronous Reset.
- The arbiter holds the FSM, pointer, Rem counter and Grant/Done registers.

## Test plan
- Reset: drive Reset=0 mid-RUN, then release. Required: all outputs 0, and an asserted Req gets Grant one cycle after release.
- Single burst: Req=01, Len0=3, Hold=0. Required: Grant=01; Gray 000, 001, 011, 010; Done=01 in the cycle Gray=010; Grant=00 the next cycle.
- Tie and fairness: Req=11 held with Len0=Len1=2. Required: grants alternate 01, 10, 01, each after a one-cycle IDLE gap.
- Wrap: Req=10, Len1=8. Required: Gray runs 001..100 then 000, with Wrap=1 only on the 000 cycle, and Done=10 in that same cycle.
- Hold and abort: Len0=5; hold for 2 cycles after the second step, so Gray stays 011 with no pulses. Then drop Req[0]. Required: IDLE next cycle, Done stays 00, Gray holds.
- Zero length: Req=01, Len0=0. Required: Grant=01 for one cycle, Done=01 in that cycle, Gray=000, no Wrap.
